// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: entry field sizing,
// counter initialisation value and the table-maintenance FSM encodings.
package branch_target_buffer_pkg;

  // Instructions are 4-byte aligned, so the two LSBs never take part in lookup.
  localparam int BTB_PC_ALIGN_W = 2;

  typedef enum logic {
    BTB_INIT  = 1'b0,
    BTB_READY = 1'b1
  } btb_state_t;

  function automatic int btb_entry_w(int addr_w, int tag_w, int ctr_w);
    return 1 + tag_w + addr_w + ctr_w;
  endfunction

  // Newly allocated entries start weakly taken.
  function automatic int btb_ctr_init(int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for a CTR_W-bit up/down saturating direction counter.
module btb_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != {CTR_W{1'b1}}) ctr_next = ctr + 1'b1;
    end else begin
      if (ctr != {CTR_W{1'b0}}) ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Tagged direct-mapped BTB with two fetch lanes (fetch_pc, fetch_pc+4),
// commit-stage training and a power-up / flush clearing sweep.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred0_hit,
  output logic              pred0_taken,
  output logic              pred1_hit,
  output logic              pred1_taken,
  output logic              pred_take,
  output logic [ADDR_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              upd_correct
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int IDX_LSB = BTB_PC_ALIGN_W;
  localparam int TAG_LSB = IDX_LSB + INDEX_W;
  localparam int ENTRY_W = btb_entry_w(ADDR_W, TAG_W, CTR_W);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(btb_ctr_init(CTR_W));

  btb_state_t         state_reg, state_next;
  logic [INDEX_W-1:0] ptr_reg, ptr_next;

  logic               valid_reg  [ENTRIES];
  logic [TAG_W-1:0]   tag_reg    [ENTRIES];
  logic [ADDR_W-1:0]  target_reg [ENTRIES];
  logic [CTR_W-1:0]   ctr_reg    [ENTRIES];

  assign ready = (state_reg == BTB_READY);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BTB_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      BTB_INIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == {INDEX_W{1'b1}}) state_next = BTB_READY;
      end
      BTB_READY: begin
        if (flush) begin
          state_next = BTB_INIT;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = BTB_INIT;
        ptr_next   = '0;
      end
    endcase
  end

  // ---------------- Fetch lookup (two lanes) ----------------
  logic [1:0]        lane_hit;
  logic [1:0]        lane_taken;
  logic [ADDR_W-1:0] lane_target [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [ADDR_W-1:0]  pc;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               lane_unused;

    // Lane1 address wraps modulo 2^ADDR_W; a carry may change both index and tag.
    assign pc          = fetch_pc + ADDR_W'(4 * gi);
    assign idx         = pc[TAG_LSB-1:IDX_LSB];
    assign tag         = pc[TAG_LSB+TAG_W-1:TAG_LSB];
    assign lane_unused = ^pc;

    assign lane_hit[gi]    = ready & valid_reg[idx] & (tag_reg[idx] == tag);
    assign lane_taken[gi]  = lane_hit[gi] & ctr_reg[idx][CTR_W-1];
    assign lane_target[gi] = target_reg[idx];
  end

  assign pred0_hit   = lane_hit[0];
  assign pred0_taken = lane_taken[0];
  assign pred1_hit   = lane_hit[1];
  assign pred1_taken = lane_taken[1];
  assign pred_take   = |lane_taken;
  assign pred_pc     = lane_taken[0] ? lane_target[0] :
                       lane_taken[1] ? lane_target[1] : '0;

  // ---------------- Commit-stage training ----------------
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic               u_pred_taken;
  logic               upd_en;
  logic [CTR_W-1:0]   u_ctr_next;
  logic               upd_unused;

  assign u_idx        = upd_pc[TAG_LSB-1:IDX_LSB];
  assign u_tag        = upd_pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign upd_unused   = ^upd_pc ^ ^ENTRY_W[0];
  assign u_hit        = valid_reg[u_idx] & (tag_reg[u_idx] == u_tag);
  assign u_pred_taken = u_hit & ctr_reg[u_idx][CTR_W-1];

  assign upd_correct = upd_valid & ready & (u_pred_taken == upd_taken) &
                       (~upd_taken | (target_reg[u_idx] == upd_target));

  // Flush takes priority over a same-cycle update.
  assign upd_en = upd_valid & ready & ~flush & ~rst;

  btb_sat_counter #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr      (ctr_reg[u_idx]),
    .taken    (upd_taken),
    .ctr_next (u_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst && state_reg == BTB_INIT) begin
      valid_reg[ptr_reg] <= 1'b0;
      ctr_reg[ptr_reg]   <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        ctr_reg[u_idx] <= u_ctr_next;
        if (upd_taken) target_reg[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_reg[u_idx]  <= 1'b1;
        tag_reg[u_idx]    <= u_tag;
        target_reg[u_idx] <= upd_target;
        ctr_reg[u_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed table vectors plus randomized traffic checked against a plain
// arithmetic model of the branch target buffer (16 entries, 2-bit counters).
module tb_branch_target_buffer;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 10;
  localparam int CTR_W   = 2;
  localparam int N       = 16;
  localparam int CMAX    = 3;
  localparam int CHALF   = 2;
  localparam logic [31:0] NE = 32'd16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred0_hit, pred0_taken, pred1_hit, pred1_taken, pred_take;
  logic [ADDR_W-1:0] pred_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_correct;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .CTR_W(CTR_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready), .fetch_pc(fetch_pc),
    .pred0_hit(pred0_hit), .pred0_taken(pred0_taken),
    .pred1_hit(pred1_hit), .pred1_taken(pred1_taken),
    .pred_take(pred_take), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_correct(upd_correct)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  bit          m_valid  [N];
  int          m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  bit          m_ready;
  int          m_cnt;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 32'd4) % NE);
  endfunction

  function automatic int m_tagof(logic [31:0] pc);
    return int'((pc / (32'd4 * NE)) % 32'd1024);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_ready && m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= CHALF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic fl);
    fetch_pc   = fpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    flush      = fl;
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    set_in(fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Clock edge: the model consumes the inputs present at the edge.
  task automatic adv();
    int i;
    @(posedge clk);
    $display("txn t=%0t rst=%0b fl=%0b upd=%0b pc=%h tk=%0b tgt=%h fetch=%h rdy=%0b",
             $time, rst, flush, upd_valid, upd_pc, upd_taken, upd_target, fetch_pc, ready);
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
          m_valid[k] = 1'b0;
          m_ctr[k]   = 0;
        end
      end
    end else if (flush) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (upd_valid) begin
      i = m_idx(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i]    = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = m_tagof(upd_pc);
        m_target[i] = upd_target;
        m_ctr[i]    = CHALF;
      end
    end
    #1;
  endtask

  task automatic lk(input string nm, input logic h0, input logic t0, input logic h1,
                    input logic t1, input logic [31:0] ppc);
    chk({nm, "_hit0"}, pred0_hit, h0);
    chk({nm, "_tk0"},  pred0_taken, t0);
    chk({nm, "_hit1"}, pred1_hit, h1);
    chk({nm, "_tk1"},  pred1_taken, t1);
    chk({nm, "_take"}, pred_take, t0 | t1);
    chk({nm, "_pc"},   pred_pc, ppc);
  endtask

  task automatic check_model();
    logic [31:0] l1, ep;
    bit t0, t1, ec;
    l1 = fetch_pc + 32'd4;
    t0 = m_taken(fetch_pc);
    t1 = m_taken(l1);
    ep = t0 ? m_target[m_idx(fetch_pc)] : (t1 ? m_target[m_idx(l1)] : 32'h0);
    ec = m_ready && upd_valid && (m_taken(upd_pc) == upd_taken) &&
         (!upd_taken || m_target[m_idx(upd_pc)] == upd_target);
    chk("rnd_ready", ready, m_ready);
    lk("rnd", m_hit(fetch_pc), t0, m_hit(l1), t1, ep);
    chk("rnd_correct", upd_correct, ec);
  endtask

  typedef struct {
    logic [31:0] fpc;
    logic        h0, t0, h1, t1;
    logic [31:0] ppc;
  } vec_t;

  vec_t dual_v [5];
  vec_t miss_v [3];
  int   nt_corr [3];
  int   tk_corr [4];
  int   tk_pred [4];

  initial begin
    dual_v[0] = '{32'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200};
    dual_v[1] = '{32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200};
    dual_v[2] = '{32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300};
    dual_v[3] = '{32'h7C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    dual_v[4] = '{32'h38, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    miss_v[0] = '{32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    miss_v[1] = '{32'h7C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    miss_v[2] = '{32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    nt_corr   = '{0, 1, 1};
    tk_corr   = '{0, 0, 1, 1};
    tk_pred   = '{0, 1, 1, 1};
    m_ready   = 1'b0;
    m_cnt     = 0;
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = 0; m_target[k] = 32'h0; m_ctr[k] = 0;
    end

    // Reset state
    rst = 1'b1;
    idle(32'h0);
    adv();
    adv();
    chk("reset_ready", ready, 1'b0);

    // Init sweep, interrupted by a reset at cycle 8
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_in(32'h40, c == 3, 32'h40, 1'b1, 32'h100, 1'b0);
      chk("init1_ready", ready, 1'b0);
      adv();
    end
    rst = 1'b1;
    idle(32'h40);
    adv();
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      set_in(32'h40, (c == 3) || (c == 10), 32'h40, 1'b1, 32'h100, 1'b0);
      chk("init2_ready", ready, c >= 16);
      lk("init2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("init2_correct", upd_correct, 1'b0);
      adv();
    end

    // Allocation; the update cycle itself still misses
    set_in(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    chk("alloc_same_hit", pred0_hit, 1'b0);
    chk("alloc_correct", upd_correct, 1'b0);
    adv();
    idle(32'h40);
    lk("alloc", 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);

    // Counter saturation: 2 -> 1,0,0 then 1,2,3,3, then 3 -> 2
    for (int k = 0; k < 3; k++) begin
      set_in(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      chk("nt_correct", upd_correct, nt_corr[k]);
      adv();
      idle(32'h40);
      chk("nt_hit0", pred0_hit, 1'b1);
      chk("nt_tk0", pred0_taken, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      set_in(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
      chk("tk_correct", upd_correct, tk_corr[k]);
      adv();
      idle(32'h40);
      chk("tk_tk0", pred0_taken, tk_pred[k]);
    end
    set_in(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    adv();
    idle(32'h40);
    chk("sat_hi_tk0", pred0_taken, 1'b1);

    // Dual lane and lane1 index wrap
    set_in(32'h0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0);
    chk("retarget_correct", upd_correct, 1'b0);
    adv();
    set_in(32'h0, 1'b1, 32'h44, 1'b1, 32'h300, 1'b0);
    adv();
    for (int k = 0; k < 5; k++) begin
      idle(dual_v[k].fpc);
      lk("dual", dual_v[k].h0, dual_v[k].t0, dual_v[k].h1, dual_v[k].t1, dual_v[k].ppc);
    end

    // Tag aliasing at index 0
    set_in(32'h0, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0);
    adv();
    idle(32'h40);
    lk("alias40", 1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
    idle(32'h7C);
    lk("alias7c", 1'b0, 1'b0, 1'b1, 1'b1, 32'h500);
    set_in(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    chk("miss_nt_correct", upd_correct, 1'b1);
    adv();
    idle(32'h80);
    lk("alias80", 1'b1, 1'b1, 1'b0, 1'b0, 32'h500);

    // Wrong target then right target
    set_in(32'h0, 1'b1, 32'h80, 1'b1, 32'h504, 1'b0);
    chk("badtgt_correct", upd_correct, 1'b0);
    adv();
    set_in(32'h0, 1'b1, 32'h80, 1'b1, 32'h504, 1'b0);
    chk("goodtgt_correct", upd_correct, 1'b1);
    adv();

    // Flush with concurrent update; flush during the sweep is ignored
    set_in(32'h40, 1'b1, 32'h44, 1'b1, 32'h999, 1'b1);
    chk("flush_ready", ready, 1'b1);
    adv();
    for (int c = 0; c <= 16; c++) begin
      set_in(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, c == 5);
      chk("flush_ready_cnt", ready, c >= 16);
      chk("flush_correct", upd_correct, c >= 16);
      if (c < 16) lk("flush_init", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      idle(miss_v[k].fpc);
      lk("postflush", miss_v[k].h0, miss_v[k].t0, miss_v[k].h1, miss_v[k].t1, miss_v[k].ppc);
    end

    // Randomized traffic against the model
    for (int r = 0; r < 400; r++) begin
      logic [31:0] fpc, upc, tgt;
      fpc = 32'($urandom_range(0, 3)) * 32'd64 + 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 19) == 0) fpc = 32'hFFFF_FFFC;
      upc = 32'($urandom_range(0, 3)) * 32'd64 + 32'($urandom_range(0, 15)) * 32'd4;
      tgt = 32'($urandom_range(0, 7)) * 32'h40;
      set_in(fpc, $urandom_range(0, 9) < 7, upc, $urandom_range(0, 1) == 1, tgt,
             $urandom_range(0, 99) == 0);
      check_model();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, tagged, direct-mapped branch target buffer with saturating-counter direction prediction.
- Serves the dual-issue fetch stage: two consecutive instruction lanes are looked up per fetch, and the block returns a redirect PC.
- Trained from the commit stage; also reports whether the committing branch was correctly predicted.
- Next-generation replacement for the untagged 1-bit testbench predictor.

Parameters:
ADDR_W, 32, PC width in bits
INDEX_W, 8, log2 of entry count (256 entries)
TAG_W, 10, stored tag bits; constraint INDEX_W+TAG_W+2 <= ADDR_W
CTR_W, 2, saturating direction counter width (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  invalidate whole table (re-runs init sweep)
ready  out  1  table initialised; lookups and updates are live
fetch_pc  in  ADDR_W  lane0 PC; lane1 PC = fetch_pc+4
pred0_hit  out  1  lane0 tag hit
pred0_taken  out  1  lane0 predicted taken (hit & counter MSB)
pred1_hit  out  1  lane1 tag hit
pred1_taken  out  1  lane1 predicted taken
pred_take  out  1  pred0_taken | pred1_taken
pred_pc  out  ADDR_W  redirect target: lane0 target if pred0_taken, else lane1 target, else 0
upd_valid  in  1  commit-stage branch resolution valid
upd_pc  in  ADDR_W  PC of the resolved branch
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target
upd_correct  out  1  prediction for upd_pc matched the actual outcome

Behaviour:
- Address split: idx = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]. Lane1 uses the index and tag of fetch_pc+4, computed modulo 2^ADDR_W, so index wrap-around and carry into the tag bits are inherent.
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W]. Counter predicts taken when its MSB is 1.
- Lookup and upd_correct are combinational from the registered table, with zero latency. A same-cycle update is not bypassed; lookups see the pre-edge state.
- upd_correct = upd_valid & ready & (predicted_taken(upd_pc) == upd_taken) & (!upd_taken | stored_target == upd_target).
  - predicted_taken(upd_pc) is 0 on a miss.
  - So a miss with a not-taken outcome counts as correct.
- FSM states are INIT and READY.
  - rst: state<=INIT, ptr<=0. No entry is cleared in the reset cycle.
  - INIT, rst low: clear valid and ctr of entry ptr; ptr<=ptr+1. At ptr = 2^INDEX_W-1, go to READY after that edge.
  - ready=1 only in READY. It first rises 2^INDEX_W cycles after rst deasserts.
  - READY & flush: state<=INIT, ptr<=0. flush during INIT is ignored (the sweep continues).
  - rst mid-INIT restarts the sweep at 0.
- While not ready:
  - all pred outputs are 0;
  - upd_correct = 0;
  - updates are dropped.
- Update rules in READY, on the clk edge with upd_valid:
  - Hit, taken: ctr = min(ctr+1, 2^CTR_W-1); target <= upd_target.
  - Hit, not-taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, taken: allocate/overwrite. Set valid=1, tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, not-taken: no change.
- flush and upd_valid in the same READY cycle: flush wins and the update is dropped.
- Lane0 and lane1 may hit the same physical entry only when INDEX_W=0. That case is unsupported; require INDEX_W >= 1.

Decomposition:
- Shared package (define.v style) holds:
  - the BTB entry field widths;
  - the counter init constant 2^(CTR_W-1);
  - FSM state encodings BTB_INIT and BTB_READY.
- One sub-module: btb_sat_counter. Combinational next-counter given the current value, the taken bit and CTR_W, with saturation at both ends.
- The table arrays, index/tag extraction and FSM remain in the top module.

Test Plan:
- Init sweep, INDEX_W=4: drop rst at cycle 0 → ready=0 through cycle 15 and ready=1 at cycle 16. Updates issued at cycles 3 and 10 are dropped, and lookups return zeros during init. Re-asserting rst at cycle 8 restarts the count.
- Allocation: update pc=0x40, taken, target=0x100, then lookup fetch_pc=0x40 → pred0_hit=1, pred0_taken=1, pred_take=1, pred_pc=0x100. A same-cycle lookup in the update cycle still misses.
- Counter saturation, CTR_W=2: after allocation ctr=2; not-taken ×3 → ctr 1, 0, 0 and pred0_taken=0 with pred0_hit=1; taken ×4 → 1, 2, 3, 3.
- Dual lane: entries at 0x40 (target 0x200) and 0x44 (target 0x300), both taken.
  - fetch_pc=0x3C → pred1_taken=1, pred_pc=0x200.
  - fetch_pc=0x40 → both lanes taken, pred_pc=0x200 (lane0 priority).
  - Lane1 index wraps at fetch_pc=0x3C with INDEX_W=4: lane0 index 15, lane1 index 0.
- Tag aliasing, INDEX_W=4: 0x40 and 0x80 both map to index 0. Update 0x80 taken → lookup 0x40 misses. Not-taken update at 0x40 → no change; 0x80 still hits.
- upd_correct and flush:
  - Stored 0x40→0x100 taken; update 0x40 taken with target 0x104 → upd_correct=0.
  - Miss with not-taken → upd_correct=1.
  - flush with a concurrent upd_valid → ready=0 for 2^INDEX_W cycles, then all lookups miss.
